// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin burst arbiter sharing one RAM port between NR readers and one writer
module ram_port_arbiter #(
    parameter int NR        = 3,
    parameter int AW        = 28,
    parameter int DW        = 128,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NR-1:0]      rd_req,
    input  logic [NR*AW-1:0]   rd_addr,
    output logic [NR-1:0]      rd_gnt,
    output logic [NR-1:0]      rd_valid,
    output logic [DW-1:0]      rd_data,
    input  logic               wr_req,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    input  logic [DW/8-1:0]    wr_strb,
    output logic               wr_gnt,
    output logic               ram_en,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_wdata,
    output logic [DW/8-1:0]    ram_wstrb,
    input  logic [DW-1:0]      ram_rdata
);

    localparam int NQ = NR + 1;
    localparam int IW = (NQ > 1) ? $clog2(NQ) : 1;
    localparam int CW = 8;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   owner, owner_nx;
    logic [IW-1:0]   rr_ptr, rr_ptr_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [NQ-1:0]   req;
    logic [NQ-1:0]   gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    int              scan;

    logic            tag_valid;
    logic [IW-1:0]   tag_idx;
    logic [NR-1:0]   rd_valid_nx;

    assign req = {wr_req, rd_req};

    // Owner keeps the port while it requests and has burst budget left; otherwise
    // a round-robin scan from rr_ptr picks the winner in the same cycle.
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        cnt_nx    = cnt;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        if (state == HOLD && req[owner] && cnt < CW'(MAX_BURST)) begin
            gnt_any = 1'b1;
            gnt_idx = owner;
            cnt_nx  = cnt + CW'(1);
        end else begin
            state_nx = IDLE;
            // Scanning downward lets the lowest offset from rr_ptr overwrite the others.
            for (int k = NR; k >= 0; k--) begin
                scan = int'(rr_ptr) + k;
                if (scan >= NQ) begin
                    scan = scan - NQ;
                end
                if (req[IW'(scan)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IW'(scan);
                end
            end
            if (gnt_any) begin
                state_nx  = HOLD;
                owner_nx  = gnt_idx;
                cnt_nx    = CW'(1);
                rr_ptr_nx = (gnt_idx == IW'(NR)) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any && !rst) begin
            gnt = NQ'(1) << gnt_idx;
        end
    end

    assign rd_gnt    = gnt[NR-1:0];
    assign wr_gnt    = gnt[NR];
    assign ram_en    = |gnt;
    assign ram_we    = gnt[NR];
    assign ram_wdata = wr_data;
    assign ram_wstrb = gnt[NR] ? wr_strb : '0;

    always_comb begin
        ram_addr = wr_addr;
        for (int i = 0; i < NR; i++) begin
            if (gnt[i]) begin
                ram_addr = rd_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        rd_valid_nx = '0;
        if (tag_valid) begin
            rd_valid_nx = NR'(1) << tag_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_ptr_nx;
            cnt    <= cnt_nx;
        end
    end

    // Read return: tag stage at the grant edge, data capture one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_idx   <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
        end else begin
            tag_valid <= |rd_gnt;
            tag_idx   <= gnt_idx;
            rd_valid  <= rd_valid_nx;
            if (tag_valid) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - randomized and directed bench for ram_port_arbiter against a queue-based model
module tb_ram_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 8;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    typedef struct {
        int             inst;
        int             due;
        int             idx;
        logic [DW-1:0]  d;
    } ret_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      rd_req;
    logic [NR*AW-1:0]   rd_addr;
    logic               wr_req;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [SW-1:0]      wr_strb;

    logic [NR-1:0]      rd_gnt_o   [2];
    logic [NR-1:0]      rd_valid_o [2];
    logic [DW-1:0]      rd_data_o  [2];
    logic               wr_gnt_o   [2];
    logic               ram_en_o   [2];
    logic               ram_we_o   [2];
    logic [AW-1:0]      ram_addr_o [2];
    logic [DW-1:0]      ram_wdata_o[2];
    logic [SW-1:0]      ram_wstrb_o[2];
    logic [DW-1:0]      ram_rdata_i[2];

    logic [DW-1:0]      mem     [2][256];
    logic [DW-1:0]      ref_mem [2][256];
    logic               ram_inited = 1'b0;

    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 m_owner [2];
    int                 m_beats [2];
    int                 m_next  [2];
    logic [DW-1:0]      last_d  [2];
    ret_t               pq[$];

    ram_port_arbiter #(.NR(NR), .AW(AW), .DW(DW), .MAX_BURST(2)) dut_b2 (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_o[0]),
        .rd_valid(rd_valid_o[0]), .rd_data(rd_data_o[0]),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_gnt(wr_gnt_o[0]), .ram_en(ram_en_o[0]), .ram_we(ram_we_o[0]),
        .ram_addr(ram_addr_o[0]), .ram_wdata(ram_wdata_o[0]), .ram_wstrb(ram_wstrb_o[0]),
        .ram_rdata(ram_rdata_i[0])
    );

    ram_port_arbiter #(.NR(NR), .AW(AW), .DW(DW), .MAX_BURST(8)) dut_b8 (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_o[1]),
        .rd_valid(rd_valid_o[1]), .rd_data(rd_data_o[1]),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_gnt(wr_gnt_o[1]), .ram_en(ram_en_o[1]), .ram_we(ram_we_o[1]),
        .ram_addr(ram_addr_o[1]), .ram_wdata(ram_wdata_o[1]), .ram_wstrb(ram_wstrb_o[1]),
        .ram_rdata(ram_rdata_i[1])
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return {32'(i) ^ 32'hDEADBEEF, 32'(i * 7), ~32'(i), 32'(i) + 32'h1000};
    endfunction

    function automatic int mbv(input int j);
        return (j == 0) ? 2 : 8;
    endfunction

    // RAM with one-cycle read latency, one per DUT
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int j = 0; j < 2; j++)
                for (int i = 0; i < 256; i++)
                    mem[j][i] <= pat(i);
            ram_inited <= 1'b1;
        end
        for (int j = 0; j < 2; j++) begin
            if (ram_en_o[j]) begin
                if (ram_we_o[j]) begin
                    for (int b = 0; b < SW; b++)
                        if (ram_wstrb_o[j][b])
                            mem[j][ram_addr_o[j]][b*8 +: 8] <= ram_wdata_o[j][b*8 +: 8];
                end else begin
                    ram_rdata_i[j] <= mem[j][ram_addr_o[j]];
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int enc(input int j);
        logic [3:0] g;
        int r;
        g = {wr_gnt_o[j], rd_gnt_o[j]};
        r = -1;
        for (int i = 3; i >= 0; i--)
            if (g[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_owner[j] = -1;
            m_beats[j] = 0;
            m_next[j]  = 0;
            last_d[j]  = '0;
        end
        pq.delete();
    endtask

    task automatic model_pick(input int j, input logic [3:0] r, output int w);
        w = -1;
        if (m_owner[j] >= 0 && r[m_owner[j]] && m_beats[j] < mbv(j)) begin
            w = m_owner[j];
            m_beats[j]++;
        end else begin
            for (int k = 0; k < 4; k++)
                if (w < 0 && r[(m_next[j] + k) % 4]) w = (m_next[j] + k) % 4;
            m_owner[j] = w;
            if (w >= 0) begin
                m_beats[j] = 1;
                m_next[j]  = (w + 1) % 4;
            end
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        int             w;
        int             hit;
        logic [3:0]     r;
        logic [3:0]     ev;
        logic [AW-1:0]  ea;
        logic [NR-1:0]  exp_v;
        logic [DW-1:0]  exp_d;
        @(negedge clk);
        if (rst) model_reset();
        r = {wr_req, rd_req};
        for (int j = 0; j < 2; j++) begin
            w = -1;
            if (!rst) model_pick(j, r, w);
            ev = (w < 0) ? 4'd0 : 4'(1 << w);
            check_val($sformatf("gnt[%0d]", j), DW'({wr_gnt_o[j], rd_gnt_o[j]}), DW'(ev));
            check_val($sformatf("ram_en[%0d]", j), DW'(ram_en_o[j]), DW'(w >= 0));
            check_val($sformatf("ram_we[%0d]", j), DW'(ram_we_o[j]), DW'(w == 3));
            if (w >= 0) begin
                ea = (w == 3) ? wr_addr : rd_addr[w*AW +: AW];
                check_val($sformatf("ram_addr[%0d]", j), DW'(ram_addr_o[j]), DW'(ea));
                check_val($sformatf("ram_wstrb[%0d]", j), DW'(ram_wstrb_o[j]), DW'((w == 3) ? wr_strb : '0));
                check_val($sformatf("ram_wdata[%0d]", j), ram_wdata_o[j], wr_data);
                if (w == 3) begin
                    for (int b = 0; b < SW; b++)
                        if (wr_strb[b]) ref_mem[j][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
                end else begin
                    pq.push_back('{inst: j, due: cyc + 2, idx: w, d: ref_mem[j][ea]});
                end
            end
            exp_v = '0;
            exp_d = last_d[j];
            hit = -1;
            foreach (pq[q])
                if (pq[q].inst == j && pq[q].due == cyc) hit = q;
            if (hit >= 0) begin
                exp_v = NR'(1 << pq[hit].idx);
                exp_d = pq[hit].d;
                pq.delete(hit);
            end
            check_val($sformatf("rd_valid[%0d]", j), DW'(rd_valid_o[j]), DW'(exp_v));
            check_val($sformatf("rd_data[%0d]", j), rd_data_o[j], exp_d);
            last_d[j] = exp_d;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req  = '0;
        wr_req  = 1'b0;
        wr_strb = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int exp_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int gcount;
    int vcount;
    logic [DW-1:0] pv;
    logic [DW-1:0] wd;

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        idle_inputs();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 256; i++)
                ref_mem[j][i] = pat(i);
        model_reset();
        step();
        step();
        rst = 1'b0;

        // single read of 0x10 by reader 1
        rd_req = 3'b010;
        rd_addr[AW +: AW] = 8'h10;
        #1;
        check_val("single_gnt", DW'(rd_gnt_o[0]), DW'(3'b010));
        check_val("single_addr", DW'(ram_addr_o[0]), DW'(8'h10));
        check_val("single_we", DW'(ram_we_o[0]), DW'(0));
        step();
        rd_req = '0;
        step();
        check_val("single_valid", DW'(rd_valid_o[0]), DW'(3'b010));
        check_val("single_data", rd_data_o[0], pat(16));
        step();

        // all four held with MAX_BURST=2
        do_reset();
        rd_addr = {8'h33, 8'h22, 8'h11};
        wr_addr = 8'h40;
        wr_data = {4{32'hA5A5_0000}};
        wr_strb = '1;
        rd_req  = 3'b111;
        wr_req  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_val($sformatf("order%0d", c), DW'(enc(0)), DW'(exp_seq[c]));
            step();
        end

        // reader 0 alone for 20 cycles, MAX_BURST=8
        do_reset();
        rd_req = 3'b001;
        gcount = 0;
        vcount = 0;
        for (int c = 0; c < 23; c++) begin
            if (c == 20) rd_req = '0;
            #1;
            if (rd_gnt_o[1][0]) gcount++;
            if (rd_valid_o[1][0]) vcount++;
            step();
        end
        check_val("solo_gnts", DW'(gcount), DW'(20));
        check_val("solo_valids", DW'(vcount), DW'(20));

        // reader 2 drops after three beats while the writer waits
        do_reset();
        wr_addr = 8'h20;
        rd_req  = 3'b100;
        step();
        wr_req  = 1'b1;
        step();
        step();
        rd_req  = '0;
        #1;
        check_val("drop_wr_gnt", DW'(wr_gnt_o[1]), DW'(1));
        step();

        // partial write then read-back of the merged word
        do_reset();
        wd      = {4{32'h1234_5678}};
        wr_req  = 1'b1;
        wr_addr = 8'h05;
        wr_data = wd;
        wr_strb = 16'h000F;
        step();
        idle_inputs();
        rd_req  = 3'b001;
        rd_addr[0 +: AW] = 8'h05;
        step();
        rd_req  = '0;
        step();
        pv = pat(5);
        for (int j = 0; j < 2; j++)
            check_val($sformatf("merge[%0d]", j), rd_data_o[j], {pv[127:32], wd[31:0]});
        step();

        // reset the cycle after a read grant
        do_reset();
        rd_req = 3'b010;
        step();
        rd_req = 3'b110;
        wr_req = 1'b1;
        rst    = 1'b1;
        #1;
        check_val("rst_gnt", DW'({wr_gnt_o[0], rd_gnt_o[0]}), DW'(0));
        check_val("rst_en", DW'(ram_en_o[0]), DW'(0));
        check_val("rst_valid", DW'(rd_valid_o[0]), DW'(0));
        check_val("rst_data", rd_data_o[0], DW'(0));
        step();
        rst = 1'b0;
        #1;
        check_val("rst_first", DW'(enc(0)), DW'(1));
        vcount = 0;
        for (int c = 0; c < 3; c++) begin
            rd_req = (c == 0) ? 3'b110 : 3'b000;
            wr_req = 1'b0;
            #1;
            if (c > 0 && rd_valid_o[0] != 0 && rd_valid_o[0] != 3'b010) vcount++;
            step();
        end
        check_val("rst_no_stale", DW'(vcount), DW'(0));

        // randomized traffic with sticky requests and occasional resets
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0) rd_req[i] = ~rd_req[i];
            if ($urandom_range(0, 3) == 0) wr_req = ~wr_req;
            for (int i = 0; i < NR; i++)
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_strb = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
            rst = 1'b0;
        end
        idle_inputs();
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NR, default 3: number of read requesters (the mm2s_0..mm2s_2 side).
REQ-002 Parameter AW, default 28: word address width (AXI_ADDR_WIDTH-LSB).
REQ-003 Parameter DW, default 128: data width (AXI_WIDTH).
REQ-004 Parameter MAX_BURST, default 8, legal range 1..255: maximum consecutive grants to one requester per tenure.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 rd_req  in  NR  per-reader request, one bit per reader.
REQ-009 rd_addr  in  NR*AW  per-reader word address; reader i occupies slice [i*AW +: AW].
REQ-010 rd_gnt  out  NR  per-reader grant; a beat transfers when rd_req[i] and rd_gnt[i] are both 1.
REQ-011 rd_valid  out  NR  one-hot read-return strobe.
REQ-012 rd_data  out  DW  read return data, shared by all readers, qualified by rd_valid.
REQ-013 wr_req  in  1  write request.
REQ-014 wr_addr  in  AW  write word address.
REQ-015 wr_data  in  DW  write data.
REQ-016 wr_strb  in  DW/8  write byte enables.
REQ-017 wr_gnt  out  1  write grant.
REQ-018 ram_en  out  1  RAM access enable.
REQ-019 ram_we  out  1  RAM write enable.
REQ-020 ram_addr  out  AW  RAM word address.
REQ-021 ram_wdata  out  DW  RAM write data.
REQ-022 ram_wstrb  out  DW/8  RAM byte enables.
REQ-023 ram_rdata  in  DW  RAM read data, valid exactly 1 cycle after a read enable.

Function
REQ-024 Requester indices: 0..NR-1 are the readers; index NR is the writer.
REQ-025 At most one grant is asserted per cycle; each grant is combinational from the requests and registered state, and is never asserted for a requester whose request is low.
REQ-026 Requesters hold address and data stable while a request is pending, and requests do not depend on grants.
REQ-027 RAM drive: ram_en = OR of all grants; ram_we = wr_gnt; ram_addr, ram_wdata and ram_wstrb are muxed from the granted requester; ram_wdata = wr_data and ram_wstrb = 0 on reads.
REQ-028 Registered state: own_valid, owner index, rr_ptr (0..NR) and a beat counter cnt.
- IDLE state: own_valid = 0.
- HOLD state: own_valid = 1.
REQ-029 HOLD with req[owner]=1 and cnt<MAX_BURST: grant owner and increment cnt.
REQ-030 Otherwise, arbitrate round-robin.
- Winner is the first requesting index found scanning from rr_ptr upward, modulo NR+1.
- On a winner: state becomes HOLD, owner = winner, cnt = 1, rr_ptr = winner+1 mod NR+1.
- With no request: state becomes IDLE.
- There is no bubble cycle on ownership change.
REQ-031 When the owner drops its request, or when cnt reaches MAX_BURST, the owner loses priority.
- If the owner is the only requester, it re-wins in the same cycle with cnt = 1.
REQ-032 Read return: a granted read at cycle N captures the reader index in a 1-bit-valid tag pipeline stage.
- At cycle N+2: rd_data = ram_rdata (sampled at the end of cycle N+1) and rd_valid[tag] = 1 for exactly one cycle.
- Total read latency is 2 cycles, and back-to-back reads return back-to-back.
REQ-033 rd_data holds its last value when rd_valid = 0.
REQ-034 A write with wr_strb = 0 is still granted and issued.

Reset
REQ-035 While rst = 1: all grants, ram_en, ram_we and rd_valid are 0; state is IDLE; rr_ptr = 0; cnt = 0; tag valid = 0; rd_data = 0.
REQ-036 A read in flight at reset assertion is discarded: no rd_valid is produced after reset release.
REQ-037 The first arbitration after reset release starts from index 0.

Verification
REQ-038 Single reader: rd_req[1]=1, addr 0x10 for 1 cycle -> rd_gnt[1]=1, ram_addr=0x10, ram_we=0; rd_valid[1]=1 two cycles later with data from the RAM model.
REQ-039 All four requesters held continuously with MAX_BURST=2 -> grant order 0,0,1,1,2,2,W,W,0,0, with no idle cycles.
REQ-040 Reader 0 alone held for 20 cycles with MAX_BURST=8 -> rd_gnt[0] high all 20 cycles; 20 rd_valid[0] pulses, each 2 cycles after its grant.
REQ-041 Reader 2 drops its request mid-burst after 3 beats while the writer is waiting -> wr_gnt asserts in the very next cycle.
REQ-042 Write addr 0x5, strb 0x000F, then a read of 0x5 -> only bytes 0..3 are changed in the RAM model and the read returns the merged word.
REQ-043 rst asserted the cycle after a read grant -> outputs go to 0 immediately, no rd_valid appears after release, and the next grant goes to the lowest requesting index.
